// File: rtl/cmd_frame_parser_pkg.sv
// Shared constants, FSM encoding and checksum helper for the command frame parser.
// The writable-address bounds are also used by the configuration register bank.
package cmd_frame_parser_pkg;

    localparam logic [7:0]  HDR0_BYTE       = 8'hEB;
    localparam logic [7:0]  HDR1_BYTE       = 8'h90;
    localparam logic [7:0]  WR_ADDR_MIN     = 8'h02;
    localparam logic [7:0]  WR_ADDR_MAX     = 8'h15;
    localparam logic [15:0] TIMEOUT_CYC_DEF = 16'd5000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR1,
        ST_ADDR,
        ST_DHI,
        ST_DLO,
        ST_CSUM
    } state_e;

    function automatic logic [7:0] frame_csum(input logic [7:0] addr,
                                              input logic [7:0] data_hi,
                                              input logic [7:0] data_lo);
        return addr + data_hi + data_lo;
    endfunction

endpackage

// File: rtl/cmd_frame_parser_if.sv
// Byte-stream input and register-write/housekeeping outputs of the command frame parser.
interface cmd_frame_parser_if;

    logic        byte_valid_in;
    logic [7:0]  byte_in;
    logic        wr_out;
    logic [7:0]  wr_addr_out;
    logic [15:0] data_out;
    logic [15:0] frame_ok_cnt_out;
    logic [7:0]  frame_err_cnt_out;
    logic        err_flag_out;

    modport slave (
        input  byte_valid_in, byte_in,
        output wr_out, wr_addr_out, data_out,
        output frame_ok_cnt_out, frame_err_cnt_out, err_flag_out
    );

    modport master (
        output byte_valid_in, byte_in,
        input  wr_out, wr_addr_out, data_out,
        input  frame_ok_cnt_out, frame_err_cnt_out, err_flag_out
    );

endinterface

// File: rtl/cmd_frame_parser_timeout_cnt.sv
// Inter-byte idle counter: clears on load, counts while enabled, and flags expiry
// on the cycle the count reaches LIMIT-1 with no clear pending.
module cmd_frame_parser_timeout_cnt #(
    parameter logic [15:0] LIMIT = 16'd5000
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = en_i && !clr_i && (cnt_q == LIMIT - 16'd1);

endmodule

// File: rtl/cmd_frame_parser.sv
// Recognises 6-byte command frames (HDR0 HDR1 ADDR DHI DLO CSUM), issues a one-cycle
// register write for valid frames and keeps OK/error housekeeping counters.
module cmd_frame_parser
    import cmd_frame_parser_pkg::*;
#(
    parameter logic [7:0]  HDR0        = HDR0_BYTE,
    parameter logic [7:0]  HDR1        = HDR1_BYTE,
    parameter logic [7:0]  ADDR_MIN    = WR_ADDR_MIN,
    parameter logic [7:0]  ADDR_MAX    = WR_ADDR_MAX,
    parameter logic [15:0] TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic               clk_in,
    input  logic               rst_in,
    cmd_frame_parser_if.slave  bus
);

    state_e      state_q, state_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  dhi_q, dhi_d;
    logic [7:0]  dlo_q, dlo_d;
    logic        wr_q, wr_d;
    logic [7:0]  wr_addr_q, wr_addr_d;
    logic [15:0] data_q, data_d;
    logic [15:0] ok_cnt_q, ok_cnt_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic        err_flag_q, err_flag_d;

    logic byte_acc;
    logic frame_pass;
    logic err_event;
    logic tmo_expire;

    assign byte_acc   = bus.byte_valid_in;
    assign frame_pass = (bus.byte_in == frame_csum(addr_q, dhi_q, dlo_q)) &&
                        (addr_q >= ADDR_MIN) && (addr_q <= ADDR_MAX);

    // Idle counter is held clear in IDLE and on every accepted byte.
    cmd_frame_parser_timeout_cnt #(
        .LIMIT (TIMEOUT_CYC)
    ) u_timeout (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .clr_i    (byte_acc || (state_q == ST_IDLE)),
        .en_i     (state_q != ST_IDLE),
        .expire_o (tmo_expire)
    );

    // NOTE: every signal written here gets a default first; a path that leaves
    // one unassigned would infer a latch.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        dhi_d      = dhi_q;
        dlo_d      = dlo_q;
        wr_d       = 1'b0;
        wr_addr_d  = wr_addr_q;
        data_d     = data_q;
        ok_cnt_d   = ok_cnt_q;
        err_cnt_d  = err_cnt_q;
        err_flag_d = err_flag_q;
        err_event  = 1'b0;

        if (byte_acc) begin
            unique case (state_q)
                ST_IDLE: if (bus.byte_in == HDR0) state_d = ST_HDR1;
                ST_HDR1: begin
                    if (bus.byte_in == HDR1)      state_d = ST_ADDR;
                    else if (bus.byte_in != HDR0) state_d = ST_IDLE;
                end
                ST_ADDR: begin
                    addr_d  = bus.byte_in;
                    state_d = ST_DHI;
                end
                ST_DHI: begin
                    dhi_d   = bus.byte_in;
                    state_d = ST_DLO;
                end
                ST_DLO: begin
                    dlo_d   = bus.byte_in;
                    state_d = ST_CSUM;
                end
                ST_CSUM: begin
                    state_d = ST_IDLE;
                    if (frame_pass) begin
                        wr_d      = 1'b1;
                        wr_addr_d = addr_q;
                        data_d    = {dhi_q, dlo_q};
                        ok_cnt_d  = ok_cnt_q + 16'd1;
                    end else begin
                        err_event = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (tmo_expire) begin
            state_d   = ST_IDLE;
            err_event = 1'b1;
        end

        if (err_event) begin
            err_flag_d = 1'b1;
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            dhi_q      <= '0;
            dlo_q      <= '0;
            wr_q       <= 1'b0;
            wr_addr_q  <= '0;
            data_q     <= '0;
            ok_cnt_q   <= '0;
            err_cnt_q  <= '0;
            err_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            dhi_q      <= dhi_d;
            dlo_q      <= dlo_d;
            wr_q       <= wr_d;
            wr_addr_q  <= wr_addr_d;
            data_q     <= data_d;
            ok_cnt_q   <= ok_cnt_d;
            err_cnt_q  <= err_cnt_d;
            err_flag_q <= err_flag_d;
        end
    end

    assign bus.wr_out            = wr_q;
    assign bus.wr_addr_out       = wr_addr_q;
    assign bus.data_out          = data_q;
    assign bus.frame_ok_cnt_out  = ok_cnt_q;
    assign bus.frame_err_cnt_out = err_cnt_q;
    assign bus.err_flag_out      = err_flag_q;

endmodule

// File: tb/tb_cmd_frame_parser.sv
// Directed testbench for cmd_frame_parser: drives byte frames on the falling edge
// and compares outputs against hand-computed values.
module tb_cmd_frame_parser;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    cmd_frame_parser_if bus();

    cmd_frame_parser dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called at a falling edge; presents one byte for exactly one rising edge.
    task automatic put_byte(input logic [7:0] b);
        bus.byte_valid_in = 1'b1;
        bus.byte_in       = b;
        @(negedge clk);
        bus.byte_valid_in = 1'b0;
    endtask

    task automatic send6(input logic [47:0] f);
        for (int i = 5; i >= 0; i--) put_byte(f[i*8 +: 8]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        bus.byte_valid_in = 1'b0;
        bus.byte_in       = 8'h00;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.wr_out !== 1'b0) begin errors++; $display("FAIL reset_wr got %b want 0", bus.wr_out); end
        checks++;
        if (bus.wr_addr_out !== 8'h00 || bus.data_out !== 16'h0000) begin
            errors++; $display("FAIL reset_bus got %h/%h want 00/0000", bus.wr_addr_out, bus.data_out);
        end
        checks++;
        if (bus.frame_ok_cnt_out !== 16'h0 || bus.frame_err_cnt_out !== 8'h0 || bus.err_flag_out !== 1'b0) begin
            errors++; $display("FAIL reset_cnt got %h/%h/%b want 0/0/0",
                               bus.frame_ok_cnt_out, bus.frame_err_cnt_out, bus.err_flag_out);
        end
    endtask

    task automatic test_good_frame();
        send6(48'hEB_90_02_00_01_03);
        checks++;
        if (bus.wr_out !== 1'b1 || bus.wr_addr_out !== 8'h02 || bus.data_out !== 16'h0001) begin
            errors++; $display("FAIL good_write got wr=%b %h/%h want 1 02/0001", bus.wr_out, bus.wr_addr_out, bus.data_out);
        end
        checks++;
        if (bus.frame_ok_cnt_out !== 16'd1 || bus.err_flag_out !== 1'b0) begin
            errors++; $display("FAIL good_cnt got %0d flag=%b want 1 flag=0", bus.frame_ok_cnt_out, bus.err_flag_out);
        end
        @(negedge clk);
        checks++;
        if (bus.wr_out !== 1'b0 || bus.wr_addr_out !== 8'h02 || bus.data_out !== 16'h0001) begin
            errors++; $display("FAIL good_hold got wr=%b %h/%h want 0 02/0001", bus.wr_out, bus.wr_addr_out, bus.data_out);
        end
    endtask

    task automatic test_bad_checksum();
        send6(48'hEB_90_0B_12_34_52);
        checks++;
        if (bus.wr_out !== 1'b0 || bus.wr_addr_out !== 8'h02) begin
            errors++; $display("FAIL csum_nowr got wr=%b addr=%h want 0 02", bus.wr_out, bus.wr_addr_out);
        end
        checks++;
        if (bus.frame_err_cnt_out !== 8'd1 || bus.err_flag_out !== 1'b1 || bus.frame_ok_cnt_out !== 16'd1) begin
            errors++; $display("FAIL csum_err got err=%0d flag=%b ok=%0d want 1 1 1",
                               bus.frame_err_cnt_out, bus.err_flag_out, bus.frame_ok_cnt_out);
        end
        send6(48'hEB_90_05_12_34_4B);
        checks++;
        if (bus.wr_out !== 1'b1 || bus.wr_addr_out !== 8'h05 || bus.data_out !== 16'h1234 || bus.frame_ok_cnt_out !== 16'd2) begin
            errors++; $display("FAIL csum_recover got wr=%b %h/%h ok=%0d want 1 05/1234 2",
                               bus.wr_out, bus.wr_addr_out, bus.data_out, bus.frame_ok_cnt_out);
        end
    endtask

    task automatic test_addr_range();
        send6(48'hEB_90_16_00_00_16);
        checks++;
        if (bus.wr_out !== 1'b0 || bus.frame_err_cnt_out !== 8'd2) begin
            errors++; $display("FAIL addr_hi got wr=%b err=%0d want 0 2", bus.wr_out, bus.frame_err_cnt_out);
        end
        send6(48'hEB_90_01_00_00_01);
        checks++;
        if (bus.wr_out !== 1'b0 || bus.frame_err_cnt_out !== 8'd3) begin
            errors++; $display("FAIL addr_lo got wr=%b err=%0d want 0 3", bus.wr_out, bus.frame_err_cnt_out);
        end
        send6(48'hEB_90_15_FF_FF_13);
        checks++;
        if (bus.wr_out !== 1'b1 || bus.wr_addr_out !== 8'h15 || bus.data_out !== 16'hFFFF || bus.frame_ok_cnt_out !== 16'd3) begin
            errors++; $display("FAIL addr_max got wr=%b %h/%h ok=%0d want 1 15/FFFF 3",
                               bus.wr_out, bus.wr_addr_out, bus.data_out, bus.frame_ok_cnt_out);
        end
    endtask

    task automatic test_header();
        put_byte(8'hEB);
        put_byte(8'h12);
        send6(48'hEB_90_02_00_01_03);
        checks++;
        if (bus.wr_out !== 1'b1 || bus.frame_ok_cnt_out !== 16'd4 || bus.frame_err_cnt_out !== 8'd3) begin
            errors++; $display("FAIL hdr_abort got wr=%b ok=%0d err=%0d want 1 4 3",
                               bus.wr_out, bus.frame_ok_cnt_out, bus.frame_err_cnt_out);
        end
        put_byte(8'hEB);
        send6(48'hEB_90_03_00_55_58);
        checks++;
        if (bus.wr_out !== 1'b1 || bus.wr_addr_out !== 8'h03 || bus.data_out !== 16'h0055 || bus.frame_ok_cnt_out !== 16'd5) begin
            errors++; $display("FAIL hdr_resync got wr=%b %h/%h ok=%0d want 1 03/0055 5",
                               bus.wr_out, bus.wr_addr_out, bus.data_out, bus.frame_ok_cnt_out);
        end
    endtask

    task automatic test_timeout();
        put_byte(8'hEB); put_byte(8'h90); put_byte(8'h02); put_byte(8'h00);
        idle(4999);
        checks++;
        if (bus.frame_err_cnt_out !== 8'd3) begin
            errors++; $display("FAIL tmo_early got err=%0d want 3", bus.frame_err_cnt_out);
        end
        idle(1);
        checks++;
        if (bus.frame_err_cnt_out !== 8'd4 || bus.wr_out !== 1'b0) begin
            errors++; $display("FAIL tmo_expire got err=%0d wr=%b want 4 0", bus.frame_err_cnt_out, bus.wr_out);
        end
        send6(48'hEB_90_07_00_01_08);
        checks++;
        if (bus.wr_out !== 1'b1 || bus.wr_addr_out !== 8'h07 || bus.frame_ok_cnt_out !== 16'd6) begin
            errors++; $display("FAIL tmo_idle got wr=%b addr=%h ok=%0d want 1 07 6",
                               bus.wr_out, bus.wr_addr_out, bus.frame_ok_cnt_out);
        end
        put_byte(8'hEB); put_byte(8'h90); put_byte(8'h02); put_byte(8'h00);
        idle(4999);
        put_byte(8'h05);
        put_byte(8'h07);
        checks++;
        if (bus.wr_out !== 1'b1 || bus.wr_addr_out !== 8'h02 || bus.data_out !== 16'h0005 ||
            bus.frame_ok_cnt_out !== 16'd7 || bus.frame_err_cnt_out !== 8'd4) begin
            errors++; $display("FAIL tmo_coincide got wr=%b %h/%h ok=%0d err=%0d want 1 02/0005 7 4",
                               bus.wr_out, bus.wr_addr_out, bus.data_out, bus.frame_ok_cnt_out, bus.frame_err_cnt_out);
        end
    endtask

    task automatic test_back_to_back();
        send6(48'hEB_90_04_AA_BB_69);
        checks++;
        if (bus.wr_out !== 1'b1 || bus.wr_addr_out !== 8'h04 || bus.data_out !== 16'hAABB || bus.frame_ok_cnt_out !== 16'd8) begin
            errors++; $display("FAIL b2b_first got wr=%b %h/%h ok=%0d want 1 04/AABB 8",
                               bus.wr_out, bus.wr_addr_out, bus.data_out, bus.frame_ok_cnt_out);
        end
        send6(48'hEB_90_06_01_02_09);
        checks++;
        if (bus.wr_out !== 1'b1 || bus.wr_addr_out !== 8'h06 || bus.data_out !== 16'h0102 || bus.frame_ok_cnt_out !== 16'd9) begin
            errors++; $display("FAIL b2b_second got wr=%b %h/%h ok=%0d want 1 06/0102 9",
                               bus.wr_out, bus.wr_addr_out, bus.data_out, bus.frame_ok_cnt_out);
        end
    endtask

    task automatic test_async_reset();
        put_byte(8'hEB); put_byte(8'h90); put_byte(8'h04);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.wr_addr_out !== 8'h00 || bus.data_out !== 16'h0000 || bus.wr_out !== 1'b0) begin
            errors++; $display("FAIL arst_bus got wr=%b %h/%h want 0 00/0000", bus.wr_out, bus.wr_addr_out, bus.data_out);
        end
        checks++;
        if (bus.frame_ok_cnt_out !== 16'h0 || bus.frame_err_cnt_out !== 8'h0 || bus.err_flag_out !== 1'b0) begin
            errors++; $display("FAIL arst_cnt got %0d/%0d/%b want 0/0/0",
                               bus.frame_ok_cnt_out, bus.frame_err_cnt_out, bus.err_flag_out);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        put_byte(8'h00); put_byte(8'h01); put_byte(8'h03);
        send6(48'hEB_90_02_00_01_03);
        checks++;
        if (bus.wr_out !== 1'b1 || bus.frame_ok_cnt_out !== 16'd1 || bus.frame_err_cnt_out !== 8'd0) begin
            errors++; $display("FAIL arst_clean got wr=%b ok=%0d err=%0d want 1 1 0",
                               bus.wr_out, bus.frame_ok_cnt_out, bus.frame_err_cnt_out);
        end
    endtask

    task automatic test_err_saturation();
        repeat (254) send6(48'hEB_90_0B_12_34_52);
        checks++;
        if (bus.frame_err_cnt_out !== 8'hFE) begin
            errors++; $display("FAIL sat_fe got %h want FE", bus.frame_err_cnt_out);
        end
        repeat (46) send6(48'hEB_90_0B_12_34_52);
        checks++;
        if (bus.frame_err_cnt_out !== 8'hFF || bus.err_flag_out !== 1'b1 || bus.frame_ok_cnt_out !== 16'd1) begin
            errors++; $display("FAIL sat_ff got err=%h flag=%b ok=%0d want FF 1 1",
                               bus.frame_err_cnt_out, bus.err_flag_out, bus.frame_ok_cnt_out);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_addr_range();
        test_header();
        test_timeout();
        test_back_to_back();
        test_async_reset();
        test_err_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
